// File: rtl/shift_unit_seq.sv
// Multi-cycle logical/arithmetic shifter (rotates with SHIFT_SEQ_ROTATE_EN), STEP bit positions per SHIFT cycle.
// Latency ceil(amount/STEP)+1 edges after accept; start is ignored while busy (ready=0), back-to-back accept in DONE.
module shift_unit_seq #(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_fun,
    input  logic [AMT_W-1:0] amount,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             carry_out
);

    localparam logic [3:0] OP_SRA_A = 4'b1000;
    localparam logic [3:0] OP_SRA_B = 4'b1001;
    localparam logic [3:0] OP_ROR_A = 4'b1010;
    localparam logic [3:0] OP_ROL_A = 4'b1011;
    localparam logic [3:0] OP_SRL_A = 4'b1100;
    localparam logic [3:0] OP_SLL_A = 4'b1101;
    localparam logic [3:0] OP_SRL_B = 4'b1110;
    localparam logic [3:0] OP_SLL_B = 4'b1111;

    localparam logic [AMT_W:0] STEP_W = (AMT_W+1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [3:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            OP_SRL_A, OP_SLL_A, OP_SRL_B, OP_SLL_B,
            OP_SRA_A, OP_SRA_B:  ok = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR_A, OP_ROL_A:  ok = 1'b1;
`endif
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic op_uses_b(input logic [3:0] f);
        return (f == OP_SRL_B) || (f == OP_SLL_B) || (f == OP_SRA_B);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       op_q, op_d;
    logic             wcarry_q, wcarry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             carry_out_q, carry_out_d;

    logic             accept;
    logic             op_ok;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   sra_ext;
    logic [WIDTH:0]   shl_ext;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (remaining_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    assign accept = start && ready;
    assign op_ok  = op_supported(op_q);

    // The final step of a run may be shorter than STEP.
    assign step_amt = ({1'b0, remaining_q} >= STEP_W) ? STEP_W[AMT_W-1:0] : remaining_q;

    // One guard bit beyond the register catches the last bit shifted out.
    assign shr_ext = {work_q, 1'b0} >> step_amt;
    assign sra_ext = $signed({work_q, 1'b0}) >>> step_amt;
    assign shl_ext = {1'b0, work_q} << step_amt;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [AMT_W:0] WIDTH_W = (AMT_W+1)'(WIDTH);
    logic [AMT_W:0]   rot_inv;
    logic [WIDTH-1:0] ror_val;
    logic [WIDTH-1:0] rol_val;

    assign rot_inv = WIDTH_W - {1'b0, step_amt};
    assign ror_val = (work_q >> step_amt) | (work_q << rot_inv);
    assign rol_val = (work_q << step_amt) | (work_q >> rot_inv);
`endif

    // Datapath next-state
    always_comb begin
        work_d      = work_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        wcarry_d    = wcarry_q;
        result_d    = result_q;
        flag_d      = flag_q;
        carry_out_d = carry_out_q;

        if (accept) begin
            op_d     = alu_fun;
            wcarry_d = 1'b0;
            if (op_supported(alu_fun)) begin
                work_d      = op_uses_b(alu_fun) ? b : a;
                remaining_d = amount;
            end else begin
                work_d      = '0;
                remaining_d = '0;
            end
        end else if (state_q == ST_SHIFT) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - step_amt;
                case (op_q)
                    OP_SRL_A, OP_SRL_B: begin
                        work_d   = shr_ext[WIDTH:1];
                        wcarry_d = shr_ext[0];
                    end
                    OP_SLL_A, OP_SLL_B: begin
                        work_d   = shl_ext[WIDTH-1:0];
                        wcarry_d = shl_ext[WIDTH];
                    end
                    OP_SRA_A, OP_SRA_B: begin
                        work_d   = sra_ext[WIDTH:1];
                        wcarry_d = sra_ext[0];
                    end
`ifdef SHIFT_SEQ_ROTATE_EN
                    OP_ROR_A: work_d = ror_val;
                    OP_ROL_A: work_d = rol_val;
`endif
                    default: begin
                        work_d   = work_q;
                        wcarry_d = wcarry_q;
                    end
                endcase
            end else begin
                result_d    = op_ok ? work_q : '0;
                flag_d      = op_ok;
                carry_out_d = op_ok ? wcarry_q : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_q      <= '0;
            remaining_q <= '0;
            op_q        <= '0;
            wcarry_q    <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            work_q      <= work_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            wcarry_q    <= wcarry_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign result    = result_q;
    assign flag      = flag_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: one STEP=1 and one STEP=4 instance, WIDTH=16.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i [2];
    logic [15:0] a_i     [2];
    logic [15:0] b_i     [2];
    logic [3:0]  fun_i   [2];
    logic [3:0]  amt_i   [2];
    logic        ready_o [2];
    logic        done_o  [2];
    logic        flag_o  [2];
    logic        co_o    [2];
    logic [15:0] res_o   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(16), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_i[0]), .a(a_i[0]), .b(b_i[0]),
        .alu_fun(fun_i[0]), .amount(amt_i[0]), .ready(ready_o[0]), .done(done_o[0]),
        .result(res_o[0]), .flag(flag_o[0]), .carry_out(co_o[0])
    );

    shift_unit_seq #(.WIDTH(16), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start_i[1]), .a(a_i[1]), .b(b_i[1]),
        .alu_fun(fun_i[1]), .amount(amt_i[1]), .ready(ready_o[1]), .done(done_o[1]),
        .result(res_o[1]), .flag(flag_o[1]), .carry_out(co_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges counted from the accept edge until done is seen; bounded.
    task automatic wait_done(input int u, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_o[u] && n < 64);
    endtask

    task automatic chk_outs(input int u, input string tag, input logic [15:0] er,
                            input logic ef, input logic ec);
        chk({tag, "_result"}, 32'(res_o[u]), 32'(er));
        chk({tag, "_flag"},   32'(flag_o[u]), 32'(ef));
        chk({tag, "_carry"},  32'(co_o[u]), 32'(ec));
    endtask

    // Full operation: accept, scramble inputs, wait done, check outputs and pulse width.
    // elat = ceil(amount/STEP) + 1 edges after the accept edge.
    task automatic run_op(input int u, input logic [15:0] av, input logic [15:0] bv,
                          input logic [3:0] f, input logic [3:0] am,
                          input logic [15:0] er, input logic ef, input logic ec,
                          input int elat, input string tag);
        int n;
        a_i[u] = av; b_i[u] = bv; fun_i[u] = f; amt_i[u] = am; start_i[u] = 1'b1;
        tick();
        start_i[u] = 1'b0;
        a_i[u] = ~av; b_i[u] = ~bv; amt_i[u] = ~am; fun_i[u] = ~f;
        chk({tag, "_busy_ready"}, 32'(ready_o[u]), 32'd0);
        wait_done(u, n);
        chk({tag, "_latency"}, 32'(n), 32'(elat));
        chk({tag, "_ready_at_done"}, 32'(ready_o[u]), 32'd1);
        chk_outs(u, tag, er, ef, ec);
        tick();
        chk({tag, "_done_pulse"}, 32'(done_o[u]), 32'd0);
        chk({tag, "_idle_ready"}, 32'(ready_o[u]), 32'd1);
        chk({tag, "_hold"}, 32'(res_o[u]), 32'(er));
    endtask

    initial begin
        int n;
        int pulses;
        logic [15:0] seen;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0; fun_i[i] = '0; amt_i[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(ready_o[i]), 32'd1);
            chk("rst_done",  32'(done_o[i]), 32'd0);
            chk_outs(i, "rst", 16'h0000, 1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();

        // STEP=1 logical right
        run_op(0, 16'h8001, 16'h0000, 4'b1100, 4'd3, 16'h1000, 1'b1, 1'b0, 4, "srl_a_s1");

        // STEP=1 arithmetic right, then back-to-back SLL b accepted in the DONE cycle
        a_i[0] = 16'h8001; fun_i[0] = 4'b1000; amt_i[0] = 4'd1; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        wait_done(0, n);
        chk("sra_latency", 32'(n), 32'd2);
        chk_outs(0, "sra_a_s1", 16'hC000, 1'b1, 1'b1);
        a_i[0] = 16'h1111; b_i[0] = 16'h00FF; fun_i[0] = 4'b1111; amt_i[0] = 4'd4; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        b_i[0] = 16'hAAAA;
        chk("b2b_ready_between", 32'(ready_o[0]), 32'd0);
        chk("b2b_done_between",  32'(done_o[0]), 32'd0);
        chk("b2b_result_held",   32'(res_o[0]), 32'h0000C000);
        wait_done(0, n);
        chk("b2b_latency", 32'(n), 32'd5);
        chk_outs(0, "sll_b_b2b", 16'h0FF0, 1'b1, 1'b0);
        tick();

        // Unsupported code
        run_op(0, 16'hFFFF, 16'hFFFF, 4'b0101, 4'd5, 16'h0000, 1'b0, 1'b0, 1, "unsup_0101");

        // Rotates: real with the macro, unsupported otherwise
`ifdef SHIFT_SEQ_ROTATE_EN
        run_op(0, 16'h0001, 16'h0000, 4'b1010, 4'd1, 16'h8000, 1'b1, 1'b0, 2, "ror_a_s1");
        run_op(0, 16'h8001, 16'h0000, 4'b1011, 4'd4, 16'h0018, 1'b1, 1'b0, 5, "rol_a_s1");
        run_op(1, 16'h1234, 16'h0000, 4'b1010, 4'd4, 16'h4123, 1'b1, 1'b0, 2, "ror_a_s4");
`else
        run_op(0, 16'h0001, 16'h0000, 4'b1010, 4'd1, 16'h0000, 1'b0, 1'b0, 1, "ror_a_s1");
        run_op(0, 16'h8001, 16'h0000, 4'b1011, 4'd4, 16'h0000, 1'b0, 1'b0, 1, "rol_a_s1");
        run_op(1, 16'h1234, 16'h0000, 4'b1010, 4'd4, 16'h0000, 1'b0, 1'b0, 1, "ror_a_s4");
`endif

        // STEP=4: full steps, partial final step, amount=0
        run_op(1, 16'h1238, 16'h0000, 4'b1100, 4'd4,  16'h0123, 1'b1, 1'b1, 2, "srl_a_s4");
        run_op(1, 16'h1234, 16'h0000, 4'b1101, 4'd15, 16'h0000, 1'b1, 1'b0, 5, "sll_a15_s4");
        run_op(1, 16'h1234, 16'h0000, 4'b1101, 4'd0,  16'h1234, 1'b1, 1'b0, 1, "sll_a0_s4");
        run_op(1, 16'h0000, 16'h80A0, 4'b1001, 4'd6,  16'hFE02, 1'b1, 1'b1, 3, "sra_b6_s4");

        // start during SHIFT is ignored
        a_i[0] = 16'h00F8; fun_i[0] = 4'b1100; amt_i[0] = 4'd4; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        tick();
        a_i[0] = 16'hFFFF; fun_i[0] = 4'b1101; amt_i[0] = 4'd1; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        pulses = 0;
        seen = 16'hDEAD;
        for (int i = 0; i < 12; i++) begin
            if (done_o[0]) begin
                pulses++;
                seen = res_o[0];
            end
            tick();
        end
        chk("ign_start_pulses", 32'(pulses), 32'd1);
        chk("ign_start_result", 32'(seen), 32'h0000000F);
        chk("ign_start_carry",  32'(co_o[0]), 32'd1);

        // Reset mid-operation
        a_i[0] = 16'hFFFF; fun_i[0] = 4'b1100; amt_i[0] = 4'd10; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready_o[0]), 32'd1);
        chk("midrst_done",  32'(done_o[0]), 32'd0);
        chk_outs(0, "midrst", 16'h0000, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_o[0]) pulses++;
        end
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done_o[0]) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        chk("midrst_result_after", 32'(res_o[0]), 32'd0);
        run_op(0, 16'h0003, 16'h0000, 4'b1101, 4'd2, 16'h000C, 1'b1, 1'b0, 3, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
